// File: rtl/aes_block_loader_pkg.sv
// Shared types and constants for the AES block loader.
// Contents: block/word widths and the loader FSM state type.
package aes_block_loader_pkg;

   localparam int unsigned AES_BLK_W  = 128;
   localparam int unsigned AES_WORD_W = 32;
   localparam int unsigned AES_WORDS  = AES_BLK_W / AES_WORD_W;

   typedef enum logic [2:0] {
      KEY,
      TEXT,
      LOAD,
      BUSY
   } loader_state_t;

endpackage

// File: rtl/aes_block_loader_if.sv
// Bundle of the loader's stream side (s_*) and AES core side (ld/key/text_in/mode/done/busy).
// Modports:
//   slave  - the loader: consumes the word stream and done, drives the core load signals.
//   master - the environment: drives the word stream and done, observes the loader outputs.
interface aes_block_loader_if;
   import aes_block_loader_pkg::*;

   logic                  s_valid;
   logic                  s_ready;
   logic [AES_WORD_W-1:0] s_data;
   logic                  s_mode;
   logic                  s_key_new;
   logic                  ld;
   logic [AES_BLK_W-1:0]  key;
   logic [AES_BLK_W-1:0]  text_in;
   logic                  mode;
   logic                  done;
   logic                  busy;

   modport slave (
      input  s_valid, s_data, s_mode, s_key_new, done,
      output s_ready, ld, key, text_in, mode, busy
   );

   modport master (
      output s_valid, s_data, s_mode, s_key_new, done,
      input  s_ready, ld, key, text_in, mode, busy
   );

endinterface

// File: rtl/aes_block_loader_word_packer.sv
// aes_word_packer: shifts 32-bit words into a 128-bit field, first word ending in the MSW.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   en_i          - accept word_i this cycle
//   word_i        - incoming word
//   blk_o         - packed field
//   cnt_o         - words accepted so far in the current field (wraps 3 -> 0)
//   last_o        - en_i on the 4th word of the field
module aes_word_packer
   import aes_block_loader_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  en_i,
   input  logic [AES_WORD_W-1:0] word_i,
   output logic [AES_BLK_W-1:0]  blk_o,
   output logic [1:0]            cnt_o,
   output logic                  last_o
);

   logic [AES_BLK_W-1:0] blk_q, blk_d;
   logic [1:0]           cnt_q, cnt_d;

   always_comb begin
      blk_d = blk_q;
      cnt_d = cnt_q;
      if (en_i) begin
         // After four shifts the first word sits in [127:96].
         blk_d = {blk_q[AES_BLK_W-AES_WORD_W-1:0], word_i};
         cnt_d = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         blk_q <= '0;
         cnt_q <= 2'd0;
      end else begin
         blk_q <= blk_d;
         cnt_q <= cnt_d;
      end
   end

   assign blk_o  = blk_q;
   assign cnt_o  = cnt_q;
   assign last_o = en_i && (cnt_q == 2'd3);

endmodule

// File: rtl/aes_block_loader.sv
// aes_block_loader: packs a 32-bit valid/ready word stream into 128-bit key and text_in,
// then issues a one-cycle ld to the AES core and holds everything until done.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - aes_block_loader_if.slave (stream side s_*, core side ld/key/text_in/mode/done/busy)
// Build option: AES_LOADER_KEY_CACHE_EN keeps the last key so a block may carry text only;
// s_key_new on the first text word of a block forces a fresh 4-word key.
module aes_block_loader
   import aes_block_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   aes_block_loader_if.slave bus
);

   loader_state_t state_q, state_d;
   logic ready_q, ready_d;
   logic mode_q;
   logic first_q, first_d;

   logic xfer, jump, key_en, text_en, key_last, text_last;
   logic [1:0] text_cnt, unused_key_cnt;
   logic [AES_BLK_W-1:0] key_blk, text_blk;

   assign xfer = bus.s_valid & ready_q;

`ifdef AES_LOADER_KEY_CACHE_EN
   logic key_valid_q;

   // A block starting in TEXT may request a new key; that word becomes key word 0.
   assign jump = (state_q == TEXT) && (text_cnt == 2'd0) && bus.s_key_new;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_valid_q <= 1'b0;
      end else if (key_last) begin
         key_valid_q <= 1'b1;
      end
   end
`else
   logic unused_cfg;

   assign jump       = 1'b0;
   assign unused_cfg = ^{bus.s_key_new, text_cnt};
`endif

   assign key_en  = xfer & ((state_q == KEY) | jump);
   assign text_en = xfer & (state_q == TEXT) & ~jump;

   aes_word_packer u_key_packer (
      .clk_i  (clk),
      .rst_ni (rst),
      .en_i   (key_en),
      .word_i (bus.s_data),
      .blk_o  (key_blk),
      .cnt_o  (unused_key_cnt),
      .last_o (key_last)
   );

   aes_word_packer u_text_packer (
      .clk_i  (clk),
      .rst_ni (rst),
      .en_i   (text_en),
      .word_i (bus.s_data),
      .blk_o  (text_blk),
      .cnt_o  (text_cnt),
      .last_o (text_last)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         KEY: begin
            if (key_last) state_d = TEXT;
         end
         TEXT: begin
            if (key_en) begin
               state_d = KEY;
            end else if (text_last) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            state_d = BUSY;
         end
         BUSY: begin
            if (bus.done) begin
`ifdef AES_LOADER_KEY_CACHE_EN
               state_d = key_valid_q ? TEXT : KEY;
`else
               state_d = KEY;
`endif
            end
         end
         default: begin
            state_d = KEY;
         end
      endcase
   end

   // Registered ready keeps s_ready low while reset is asserted.
   assign ready_d = (state_d == KEY) || (state_d == TEXT);

   // Marks that the next transfer opens a new block (for mode capture).
   always_comb begin
      first_d = first_q;
      if (xfer) begin
         first_d = 1'b0;
      end else if ((state_q == BUSY) && bus.done) begin
         first_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= KEY;
         ready_q <= 1'b0;
         mode_q  <= 1'b0;
         first_q <= 1'b1;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         first_q <= first_d;
         if (xfer && first_q) mode_q <= bus.s_mode;
      end
   end

   assign bus.s_ready = ready_q;
   assign bus.ld      = (state_q == LOAD);
   assign bus.busy    = (state_q == BUSY);
   assign bus.key     = key_blk;
   assign bus.text_in = text_blk;
   assign bus.mode    = mode_q;

endmodule
